haze_pass_sequencer: RTL

Frame-level controller for the two-pass haze removal datapath. Pass 1 streams the frame into atmospheric light estimation (ALE). The sequencer then stalls input until ALE reports done. Pass 2 streams the same frame through transmission estimation and scene recovery (TE/SRSC). It owns S_AXIS_TREADY, per-pass pixel counting, M_AXIS_TLAST generation and the end-of-frame pulse.

---
 rtl/haze_pass_sequencer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/haze_pass_sequencer.sv
// Frame-level sequencer for the two-pass haze removal datapath: streams a frame
// into ALE, waits for the atmospheric light, then streams it again through TE/SRSC.
module haze_pass_sequencer #(
    parameter int IMG_WIDTH   = 512,
    parameter int IMG_HEIGHT  = 512,
    parameter int CNT_W       = 18,
    parameter bit CHECK_TLAST = 1'b0
) (
    input  logic       ACLK,
    input  logic       ARESETn,
    input  logic       enable,
    input  logic       S_AXIS_TVALID,
    input  logic       S_AXIS_TLAST,
    output logic       S_AXIS_TREADY,
    output logic       ale_start,
    output logic       ale_valid,
    input  logic       ale_done,
    output logic       te_valid,
    input  logic       pipe_ready,
    input  logic       out_valid,
    output logic       M_AXIS_TLAST,
    output logic [2:0] state,
    output logic       frame_done,
    output logic       err_tlast
);

    localparam int              PIXELS   = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIXELS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PASS1    = 3'd1,
        S_WAIT_ALE = 3'd2,
        S_PASS2    = 3'd3,
        S_DRAIN    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             out_last_seen_q, out_last_seen_d;
    logic             err_q, err_d;
    logic             ale_start_q, ale_start_d;
    logic             acc, in_last, out_acc, out_last;

    always_comb begin
        state_d         = state_q;
        in_cnt_d        = in_cnt_q;
        out_cnt_d       = out_cnt_q;
        out_last_seen_d = out_last_seen_q;
        err_d           = err_q;
        ale_start_d     = 1'b0;
        S_AXIS_TREADY   = 1'b0;

        // Output beats are only meaningful while the second pass is in flight.
        out_acc  = out_valid & ((state_q == S_PASS2) | (state_q == S_DRAIN));
        out_last = out_acc & (out_cnt_q == LAST_IDX);
        if (out_acc) begin
            out_cnt_d = out_last ? '0 : out_cnt_q + 1'b1;
            if (out_last) out_last_seen_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d         = S_PASS1;
                    ale_start_d     = 1'b1;
                    err_d           = 1'b0;
                    in_cnt_d        = '0;
                    out_cnt_d       = '0;
                    out_last_seen_d = 1'b0;
                end
            end
            S_PASS1:    S_AXIS_TREADY = enable;
            S_WAIT_ALE: if (ale_done) state_d = S_PASS2;
            S_PASS2:    S_AXIS_TREADY = enable & pipe_ready;
            S_DRAIN:    if (out_last) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        acc     = S_AXIS_TVALID & S_AXIS_TREADY;
        in_last = (in_cnt_q == LAST_IDX);
        if (acc) begin
            in_cnt_d = in_last ? '0 : in_cnt_q + 1'b1;
            if (CHECK_TLAST && (S_AXIS_TLAST != in_last)) err_d = 1'b1;
            if (in_last) begin
                if (state_q == S_PASS1) state_d = S_WAIT_ALE;
                else state_d = (out_last_seen_q | out_last) ? S_DONE : S_DRAIN;
            end
        end

        ale_valid    = acc & (state_q == S_PASS1);
        te_valid     = acc & (state_q == S_PASS2);
        M_AXIS_TLAST = out_last;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q         <= S_IDLE;
            in_cnt_q        <= '0;
            out_cnt_q       <= '0;
            out_last_seen_q <= 1'b0;
            err_q           <= 1'b0;
            ale_start_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            in_cnt_q        <= in_cnt_d;
            out_cnt_q       <= out_cnt_d;
            out_last_seen_q <= out_last_seen_d;
            err_q           <= err_d;
            ale_start_q     <= ale_start_d;
        end
    end

    assign state      = state_q;
    assign ale_start  = ale_start_q;
    assign err_tlast  = err_q;
    assign frame_done = (state_q == S_DONE);

endmodule
